// File: rtl/fseq_pkg.sv
// Shared types and constants for the fetch sequencer.
//   XLEN          : address/data width
//   PC_STEP       : sequential PC increment
//   PC_ALIGN_MASK : forces word alignment of redirect targets
//   fseq_state_e  : FSM state encoding {BOOT, FETCH, WAIT, ISSUE}
package fseq_pkg;

    localparam int unsigned XLEN          = 32;
    localparam logic [31:0] PC_STEP       = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        ISSUE = 2'd3
    } fseq_state_e;

    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_seq_ctrl_if.sv
// Bus bundle between the fetch sequencer, instruction memory and decode.
//   imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata : imem handshake
//   instr_valid/instr/instr_pc/instr_ready             : decode handoff
//   redirect_valid/redirect_target                     : branch/jump redirect
//   trap_valid/epc                                     : present only with FSEQ_TRAP_EN
// master = sequencer side, slave = memory/datapath side.
interface fetch_seq_ctrl_if;
    import fseq_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;

`ifdef FSEQ_TRAP_EN
    logic            trap_valid;
    logic [XLEN-1:0] epc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, epc,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready,
               redirect_valid, redirect_target, trap_valid
    );
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, epc,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready,
               redirect_valid, redirect_target, trap_valid
    );
`else
    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready,
               redirect_valid, redirect_target
    );
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready,
               redirect_valid, redirect_target
    );
`endif

endinterface

// File: rtl/pc_load_reg.sv
// Program counter register.
//   clk, rst  : clock, asynchronous active-high reset (loads RESET_VAL)
//   ld_i      : load ld_val_i (takes precedence over inc_i)
//   ld_val_i  : value to load
//   inc_i     : advance by PC_STEP, wrapping modulo 2^32
//   pc_o      : current PC
module pc_load_reg
    import fseq_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_i,
    input  logic [XLEN-1:0] ld_val_i,
    input  logic            inc_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VAL;
        end else if (ld_i) begin
            pc_q <= ld_val_i;
        end else if (inc_i) begin
            pc_q <= pc_q + PC_STEP;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: owns the PC, issues one imem request at a time and holds
// the returned instruction until decode consumes it. Redirects override
// sequential flow; a redirect that arrives while a request is outstanding
// marks the returning word stale (kill) and remembers the new target.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch_seq_ctrl_if.master (imem handshake, decode handoff, redirect)
// Optional feature macro: FSEQ_TRAP_EN adds trap_valid/epc and the TRAP_VEC
// parameter; a trap acts as the highest-priority redirect to TRAP_VEC.
module fetch_seq_ctrl
    import fseq_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
`ifdef FSEQ_TRAP_EN
    , parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0180
`endif
) (
    input logic               clk,
    input logic               rst,
    fetch_seq_ctrl_if.master  bus
);

    localparam logic [1:0] ST_BOOT  = BOOT;
    localparam logic [1:0] ST_FETCH = FETCH;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_ISSUE = ISSUE;

    logic [1:0]      state_q, state_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic            instr_valid_q, instr_valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;

    logic [XLEN-1:0] pc;
    logic            pc_ld;
    logic [XLEN-1:0] pc_ld_val;
    logic            pc_inc;

    // Effective redirect: a trap folds into the redirect path with its own target.
    logic            redir;
    logic [XLEN-1:0] redir_tgt;

`ifdef FSEQ_TRAP_EN
    logic            trap;
    logic [XLEN-1:0] epc_q;

    assign trap      = bus.trap_valid;
    assign redir     = trap | bus.redirect_valid;
    assign redir_tgt = trap ? TRAP_VEC : pc_align(bus.redirect_target);
`else
    assign redir     = bus.redirect_valid;
    assign redir_tgt = pc_align(bus.redirect_target);
`endif

    pc_load_reg #(
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .ld_i     (pc_ld),
        .ld_val_i (pc_ld_val),
        .inc_i    (pc_inc),
        .pc_o     (pc)
    );

    always_comb begin
        state_d       = state_q;
        kill_d        = kill_q;
        tgt_d         = tgt_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        pc_ld         = 1'b0;
        pc_ld_val     = '0;
        pc_inc        = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
`ifdef FSEQ_TRAP_EN
                if (trap) begin
                    pc_ld     = 1'b1;
                    pc_ld_val = TRAP_VEC;
                end
`endif
            end
            ST_FETCH: begin
                if (bus.imem_gnt) begin
                    // Request already accepted for the old PC: drop it on return.
                    state_d = ST_WAIT;
                    if (redir) begin
                        kill_d = 1'b1;
                        tgt_d  = redir_tgt;
                    end
                end else if (redir) begin
                    pc_ld     = 1'b1;
                    pc_ld_val = redir_tgt;
                end
            end
            ST_WAIT: begin
                if (bus.imem_rvalid) begin
                    if (kill_q || redir) begin
                        kill_d    = 1'b0;
                        pc_ld     = 1'b1;
                        pc_ld_val = redir ? redir_tgt : tgt_q;
                        state_d   = ST_FETCH;
                    end else begin
                        instr_d       = bus.imem_rdata;
                        instr_pc_d    = pc;
                        instr_valid_d = 1'b1;
                        state_d       = ST_ISSUE;
                    end
                end else if (redir) begin
                    kill_d = 1'b1;
                    tgt_d  = redir_tgt;
                end
            end
            ST_ISSUE: begin
                if (redir) begin
                    pc_ld         = 1'b1;
                    pc_ld_val     = redir_tgt;
                    instr_valid_d = 1'b0;
                    state_d       = ST_FETCH;
                end else if (bus.instr_ready) begin
                    pc_inc        = 1'b1;
                    instr_valid_d = 1'b0;
                    state_d       = ST_FETCH;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            kill_q        <= 1'b0;
            tgt_q         <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            kill_q        <= kill_d;
            tgt_q         <= tgt_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

`ifdef FSEQ_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc_q <= '0;
        end else if (trap) begin
            epc_q <= (state_q == ST_ISSUE) ? instr_pc_q : pc;
        end
    end

    assign bus.epc = epc_q;
`endif

    assign bus.imem_req    = (state_q == ST_FETCH);
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;

endmodule
